scan_decoder: RTL and testbench
===============================

SCAN_DECODER -- requirements
Module: scan_decoder

Interface
REQ-001 SHALL have parameter N, default 3: select width; output width 2**N; legal range 1..6.
REQ-002 SHALL have parameter DWELL, default 4: cycles each output is held in scan mode; legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port en  input  1  block enable; 0 forces idle.
REQ-006 SHALL have port mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-007 SHALL have port i  input  N  select value (direct mode) or scan start index (scan entry).
REQ-008 SHALL have port y  output  2**N  registered one-hot decode output.
REQ-009 SHALL have port idx  output  N  index currently driven onto y.
REQ-010 SHALL have port valid  output  1  high when y holds a decoded one-hot value.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse when scan index wraps from 2**N-1 to 0.

Function
REQ-012 SHALL implement three states: IDLE, DIRECT, SCAN; all outputs registered.
REQ-013 SHALL, in any state with en=0, go to IDLE next cycle: y=0, valid=0, wrap=0, idx holds its last value.
REQ-014 SHALL, with en=1 and mode=0, go to/stay in DIRECT: y[i]=1, all other bits 0, idx=i, valid=1 one cycle after sampling i (latency 1).
REQ-015 SHALL, in DIRECT, track every change of i with the same 1-cycle latency; no glitch cycles with multiple bits set.
REQ-016 SHALL, with en=1 and mode=1 from IDLE or DIRECT, enter SCAN: load idx=i, y=onehot(i), valid=1, dwell counter=0, all on the next edge.
REQ-017 SHALL, in SCAN, ignore i; hold idx for exactly DWELL cycles, then advance idx by 1 modulo 2**N and clear the dwell counter.
REQ-018 SHALL assert wrap for exactly the one cycle in which idx first shows 0 after 2**N-1; wrap=0 in IDLE and DIRECT.
REQ-019 SHALL, with DWELL=1, advance idx every cycle.
REQ-020 SHALL, on mode 1->0 during SCAN with en=1, enter DIRECT next cycle with y=onehot(i); dwell counter discarded.
REQ-021 SHALL, on en falling during SCAN, give en priority over mode; re-entering SCAN always reloads from i.
REQ-022 SHALL guarantee y is all-zero or exactly one-hot in every cycle; y==onehot(idx) whenever valid=1.

Reset
REQ-023 SHALL, while rst_n=0, force state=IDLE, y=0, idx=0, valid=0, wrap=0, dwell counter=0, regardless of clk.
REQ-024 SHALL, on rst_n asserted mid-scan, abort immediately; first active edge after release evaluates en/mode as from IDLE.

Configuration
REQ-025 SHALL support macro SCAN_DECODER_DIR_EN: when defined, add input port dir (1 bit); dir=1 makes SCAN decrement idx modulo 2**N, and wrap pulses when idx first shows 2**N-1 after 0; dir sampled at each advance.
REQ-026 SHALL, without SCAN_DECODER_DIR_EN, have no dir port and scan upward only.

Verification
REQ-027 SHALL cover: N=3, en=1, mode=0, i=5 -> next cycle y=8'b0010_0000, idx=5, valid=1.
REQ-028 SHALL cover: N=3, DWELL=4, mode=1, i=6 -> idx=6 for 4 cycles, 7 for 4, then 0 with wrap=1 for one cycle, then 1.
REQ-029 SHALL cover: scan running, en=0 for one cycle -> y=0, valid=0; en=1, mode=1, i=2 -> reload idx=2.
REQ-030 SHALL cover: rst_n pulsed low mid-scan, asynchronous to clk -> y=0, idx=0, valid=0 before next clk edge.
REQ-031 SHALL cover: SCAN_DECODER_DIR_EN defined, dir=1, i=1, DWELL=1 -> idx 1,0,7 with wrap=1 on 7, then 6.
REQ-032 SHALL cover: N=1 and N=6 random direct/scan stimulus -> REQ-022 checked every cycle.

Source files
------------

// File: rtl/scan_decoder.sv
// -----------------------------------------------------------------------------
// scan_decoder
//   Registered N-to-2**N one-hot decoder. It has two operating modes:
//     direct    : y follows onehot(i) with one cycle of latency.
//     auto-scan : starts at i, holds each index for DWELL cycles, then steps
//                 to the next index modulo 2**N. wrap pulses for one cycle
//                 each time the index rolls over.
//   en=0 forces idle, and takes priority over mode.
//
// Parameters
//   N      select width, legal range 1..6 (output width 2**N)
//   DWELL  cycles each index is held in scan mode, legal range 1..255
//
// Ports
//   clk    clock; all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   en     block enable (0 = idle)
//   mode   0 = direct decode, 1 = auto-scan
//   i      select value (direct) or scan start index (on scan entry)
//   dir    (only with SCAN_DECODER_DIR_EN) 1 = scan downward
//   y      registered one-hot output, all-zero when not valid
//   idx    index currently driven onto y; held while idle
//   valid  y carries a decoded one-hot value
//   wrap   one-cycle pulse when the scan index rolls over
//
// Build option
//   SCAN_DECODER_DIR_EN : adds the dir input for a down-counting scan. When
//                         dir=1, wrap pulses on the step from 0 to 2**N-1.
//                         dir is sampled at each advance.
// -----------------------------------------------------------------------------
module scan_decoder #(
    parameter int unsigned N     = 3,
    parameter int unsigned DWELL = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        i,
`ifdef SCAN_DECODER_DIR_EN
    input  logic                dir,
`endif
    output logic [(2**N)-1:0]   y,
    output logic [N-1:0]        idx,
    output logic                valid,
    output logic                wrap
);

    localparam int unsigned W     = 2 ** N;
    localparam int unsigned CW    = 8;
    localparam int unsigned MAX_I = W - 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    y_nxt;
    logic [N-1:0]    idx_nxt;
    logic            valid_nxt;
    logic            wrap_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            down;

    // One-hot decode of a select value.
    function automatic logic [W-1:0] onehot(input logic [N-1:0] s);
        return W'(1) << s;
    endfunction

    // Scan direction; upward only unless the direction option is built in.
`ifdef SCAN_DECODER_DIR_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state;
        y_nxt     = y;
        idx_nxt   = idx;
        valid_nxt = valid;
        wrap_nxt  = 1'b0;
        cnt_nxt   = cnt;

        if (!en) begin
            // Idle blanks the output but keeps idx as a record of the last index.
            state_nxt = S_IDLE;
            y_nxt     = '0;
            valid_nxt = 1'b0;
            cnt_nxt   = '0;
        end else if (!mode) begin
            state_nxt = S_DIRECT;
            y_nxt     = onehot(i);
            idx_nxt   = i;
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
        end else if (state != S_SCAN) begin
            // Scan entry always reloads the start index from i.
            state_nxt = S_SCAN;
            y_nxt     = onehot(i);
            idx_nxt   = i;
            valid_nxt = 1'b1;
            cnt_nxt   = '0;
        end else if (cnt == CW'(DWELL - 1)) begin
            // End of the dwell period: step the index and note a rollover.
            cnt_nxt   = '0;
            valid_nxt = 1'b1;
            if (down) begin
                idx_nxt  = idx - N'(1);
                wrap_nxt = (idx == '0);
            end else begin
                idx_nxt  = idx + N'(1);
                wrap_nxt = (idx == N'(MAX_I));
            end
            y_nxt = onehot(idx_nxt);
        end else begin
            cnt_nxt = cnt + CW'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            y     <= '0;
            idx   <= '0;
            valid <= 1'b0;
            wrap  <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            y     <= y_nxt;
            idx   <= idx_nxt;
            valid <= valid_nxt;
            wrap  <= wrap_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_scan_decoder
//   Directed bench for scan_decoder. The main instance uses N=3, DWELL=4.
//   Two extra instances check the size extremes: N=1 with DWELL=3, and
//   N=6 with DWELL=1.
// -----------------------------------------------------------------------------
module tb_scan_decoder;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic [2:0]  i;
    logic [7:0]  y;
    logic [2:0]  idx;
    logic        valid;
    logic        wrap;

    logic        en_a;
    logic        mode_a;
    logic [0:0]  i1;
    logic [1:0]  y1;
    logic [0:0]  idx1;
    logic        v1;
    logic        w1;
    logic [5:0]  i6;
    logic [63:0] y6;
    logic [5:0]  idx6;
    logic        v6;
    logic        w6;

    int vec;
    int errs;

`ifdef SCAN_DECODER_DIR_EN
    logic dir;
    logic dir_a;
`endif

    scan_decoder #(.N(3), .DWELL(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .i(i),
`ifdef SCAN_DECODER_DIR_EN
        .dir(dir),
`endif
        .y(y), .idx(idx), .valid(valid), .wrap(wrap)
    );

    scan_decoder #(.N(1), .DWELL(3)) u_n1 (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .i(i1),
`ifdef SCAN_DECODER_DIR_EN
        .dir(dir_a),
`endif
        .y(y1), .idx(idx1), .valid(v1), .wrap(w1)
    );

    scan_decoder #(.N(6), .DWELL(1)) u_n6 (
        .clk(clk), .rst_n(rst_n), .en(en_a), .mode(mode_a), .i(i6),
`ifdef SCAN_DECODER_DIR_EN
        .dir(dir_a),
`endif
        .y(y6), .idx(idx6), .valid(v6), .wrap(w6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; i = '0;
        en_a = 1'b0; mode_a = 1'b0; i1 = '0; i6 = '0;
`ifdef SCAN_DECODER_DIR_EN
        dir = 1'b0; dir_a = 1'b0;
`endif
        #3;
        vec++;
        if ({y, idx, valid, wrap} !== 13'd0) begin
            errs++;
            $display("FAIL reset_main: got %h want 0", {y, idx, valid, wrap});
        end
        vec++;
        if ({y1, idx1, v1, w1, y6, idx6, v6, w6} !== 78'd0) begin
            errs++;
            $display("FAIL reset_aux: got %h want 0", {y1, idx1, v1, w1, y6, idx6, v6, w6});
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        vec++;
        if ({y, idx, valid, wrap} !== 13'd0) begin
            errs++;
            $display("FAIL reset_idle: got %h want 0", {y, idx, valid, wrap});
        end
    endtask

    task automatic test_direct();
        logic [2:0] vals [5];
        logic [7:0] ey;
        vals = '{3'd5, 3'd0, 3'd7, 3'd3, 3'd3};
        en = 1'b1; mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i = vals[k];
            step();
            ey = 8'd1 << vals[k];
            vec++;
            if ({y, idx, valid, wrap} !== {ey, vals[k], 1'b1, 1'b0}) begin
                errs++;
                $display("FAIL direct_%0d: got y=%b idx=%0d v=%b w=%b want y=%b idx=%0d v=1 w=0",
                         k, y, idx, valid, wrap, ey, vals[k]);
            end
        end
        en = 1'b0;
        step();
        vec++;
        if ({y, idx, valid, wrap} !== {8'd0, 3'd3, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL direct_to_idle: got y=%b idx=%0d v=%b w=%b want y=0 idx=3 v=0 w=0",
                     y, idx, valid, wrap);
        end
    endtask

    task automatic test_scan();
        logic [2:0] eidx;
        logic [7:0] ey;
        en = 1'b1; mode = 1'b1; i = 3'd6;
        for (int k = 0; k < 13; k++) begin
            step();
            eidx = 3'((6 + k / 4) % 8);
            ey   = 8'd1 << eidx;
            vec++;
            if ({y, idx, valid, wrap} !== {ey, eidx, 1'b1, (k == 8)}) begin
                errs++;
                $display("FAIL scan_%0d: got y=%b idx=%0d v=%b w=%b want y=%b idx=%0d v=1 w=%b",
                         k, y, idx, valid, wrap, ey, eidx, (k == 8));
            end
            i = 3'(k);
        end
    endtask

    task automatic test_mode_switch();
        logic [2:0] eidx;
        mode = 1'b0; i = 3'd5;
        step();
        vec++;
        if ({y, idx, valid, wrap} !== {8'b0010_0000, 3'd5, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL scan_to_direct: got y=%b idx=%0d v=%b w=%b want y=00100000 idx=5 v=1 w=0",
                     y, idx, valid, wrap);
        end
        mode = 1'b1; i = 3'd4;
        for (int k = 0; k < 5; k++) begin
            step();
            eidx = (k < 4) ? 3'd4 : 3'd5;
            vec++;
            if ({idx, valid, wrap} !== {eidx, 1'b1, 1'b0} || y !== (8'd1 << eidx)) begin
                errs++;
                $display("FAIL direct_to_scan_%0d: got y=%b idx=%0d v=%b w=%b want idx=%0d",
                         k, y, idx, valid, wrap, eidx);
            end
        end
    endtask

    task automatic test_en_drop();
        en = 1'b0;
        step();
        vec++;
        if ({y, idx, valid, wrap} !== {8'd0, 3'd5, 1'b0, 1'b0}) begin
            errs++;
            $display("FAIL en_drop: got y=%b idx=%0d v=%b w=%b want y=0 idx=5 v=0 w=0",
                     y, idx, valid, wrap);
        end
        en = 1'b1; mode = 1'b1; i = 3'd2;
        step();
        vec++;
        if ({y, idx, valid, wrap} !== {8'b0000_0100, 3'd2, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL scan_reload: got y=%b idx=%0d v=%b w=%b want y=00000100 idx=2 v=1 w=0",
                     y, idx, valid, wrap);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        vec++;
        if ({y, idx, valid, wrap} !== 13'd0) begin
            errs++;
            $display("FAIL async_reset: got y=%b idx=%0d v=%b w=%b want all 0", y, idx, valid, wrap);
        end
        #2;
        rst_n = 1'b1;
        en = 1'b1; mode = 1'b1; i = 3'd4;
        step();
        vec++;
        if ({y, idx, valid, wrap} !== {8'b0001_0000, 3'd4, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL post_reset_scan: got y=%b idx=%0d v=%b w=%b want y=00010000 idx=4 v=1 w=0",
                     y, idx, valid, wrap);
        end
    endtask

    task automatic test_dwell_one();
        logic [5:0] e6;
        logic [0:0] e1;
        en_a = 1'b1; mode_a = 1'b1; i6 = 6'd62; i1 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step();
            e6 = 6'((62 + k) % 64);
            e1 = 1'((k / 3) % 2);
            vec++;
            if ({idx6, v6, w6} !== {e6, 1'b1, (k == 2)} || y6 !== (64'd1 << e6)) begin
                errs++;
                $display("FAIL dwell1_n6_%0d: got idx=%0d v=%b w=%b want idx=%0d w=%b",
                         k, idx6, v6, w6, e6, (k == 2));
            end
            vec++;
            if ({idx1, v1, w1} !== {e1, 1'b1, (k == 6)} || y1 !== (2'd1 << e1)) begin
                errs++;
                $display("FAIL dwell3_n1_%0d: got idx=%0d v=%b w=%b want idx=%0d w=%b",
                         k, idx1, v1, w1, e1, (k == 6));
            end
        end
        en_a = 1'b0;
        step();
    endtask

`ifdef SCAN_DECODER_DIR_EN
    task automatic test_dir();
        logic [5:0] e6;
        dir_a = 1'b1; en_a = 1'b1; mode_a = 1'b1; i6 = 6'd1;
        for (int k = 0; k < 4; k++) begin
            step();
            e6 = 6'(1 - k);
            vec++;
            if ({idx6, v6, w6} !== {e6, 1'b1, (k == 2)}) begin
                errs++;
                $display("FAIL dir_down_%0d: got idx=%0d v=%b w=%b want idx=%0d w=%b",
                         k, idx6, v6, w6, e6, (k == 2));
            end
        end
        dir_a = 1'b0; en_a = 1'b0;
        step();
    endtask
`endif

    task automatic test_random();
        logic       pen;
        logic       pmode;
        logic [0:0] pi1;
        logic [5:0] pi6;
        for (int k = 0; k < 300; k++) begin
            en_a   = ($urandom_range(0, 7) != 0);
            mode_a = ($urandom_range(0, 2) != 0);
            i1     = 1'($urandom);
            i6     = 6'($urandom);
`ifdef SCAN_DECODER_DIR_EN
            dir_a  = 1'($urandom);
`endif
            pen = en_a; pmode = mode_a; pi1 = i1; pi6 = i6;
            step();
            vec++;
            if ((y6 & (y6 - 64'd1)) !== 64'd0 || (v6 ? (y6 !== (64'd1 << idx6)) : (y6 !== 64'd0))) begin
                errs++;
                $display("FAIL rand_onehot_n6_%0d: got y=%h idx=%0d v=%b", k, y6, idx6, v6);
            end
            vec++;
            if ((y1 & (y1 - 2'd1)) !== 2'd0 || (v1 ? (y1 !== (2'd1 << idx1)) : (y1 !== 2'd0))) begin
                errs++;
                $display("FAIL rand_onehot_n1_%0d: got y=%b idx=%0d v=%b", k, y1, idx1, v1);
            end
            if (!pen) begin
                vec++;
                if ({v6, w6, v1, w1} !== 4'b0000) begin
                    errs++;
                    $display("FAIL rand_idle_%0d: got v6=%b w6=%b v1=%b w1=%b want 0", k, v6, w6, v1, w1);
                end
            end else if (!pmode) begin
                vec++;
                if ({idx6, v6, w6} !== {pi6, 1'b1, 1'b0} || {idx1, v1, w1} !== {pi1, 1'b1, 1'b0}) begin
                    errs++;
                    $display("FAIL rand_direct_%0d: got idx6=%0d idx1=%0d want idx6=%0d idx1=%0d",
                             k, idx6, idx1, pi6, pi1);
                end
            end
        end
        en_a = 1'b0;
        step();
    endtask

    initial begin
        vec  = 0;
        errs = 0;
        test_reset();
        test_direct();
        test_scan();
        test_mode_switch();
        test_en_drop();
        test_async_reset();
        test_dwell_one();
`ifdef SCAN_DECODER_DIR_EN
        test_dir();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
